// File: rtl/dffram128x32_wb_ctrl.sv
// dffram128x32_wb_ctrl: Wishbone classic slave that strobes a 128x32 DFFRAM inside a 512-byte window
module dffram128x32_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        ram_EN0,
  output logic [3:0]  ram_WE0,
  output logic [6:0]  ram_A0,
  output logic [31:0] ram_Di0,
  input  logic [31:0] ram_Do0
);
  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
  state_t state, state_nxt;
  logic req, hit, ack_nxt, err_nxt, unused_ok;
  assign ram_A0 = wb_adr_i[8:2];
  assign ram_Di0 = wb_dat_i;
  assign unused_ok = &{1'b0, wb_adr_i[1:0]};
  // RST gates the strobes so a request seen during reset never reaches the macro
  always_comb begin
    req = ~RST & wb_cyc_i & wb_stb_i & (state == IDLE);
    hit = wb_adr_i[31:9] == BASE_ADDR[31:9];
    ram_EN0 = req & hit;
    ram_WE0 = (req & hit & wb_we_i) ? wb_sel_i : 4'h0;
    ack_nxt = (req & hit & wb_we_i) | ((state == RD) & wb_cyc_i);
    err_nxt = req & ~hit;
    state_nxt = (state == RD) ? (wb_cyc_i ? RESP : IDLE) :
                (state == RESP) ? IDLE :
                req ? ((hit & ~wb_we_i) ? RD : RESP) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'h0;
    end else begin
      state <= state_nxt;
      wb_ack_o <= ack_nxt;
      wb_err_o <= err_nxt;
      if (state == RD && wb_cyc_i) wb_dat_o <= ram_Do0;
    end
  end
endmodule

// File: tb/tb_dffram128x32_wb_ctrl.sv
// tb_dffram128x32_wb_ctrl: randomized bench with a word-array reference model and a macro stand-in
module tb_dffram128x32_wb_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we_i = 1'b0;
  logic [3:0] sel_i = 4'h0;
  logic [31:0] adr_i = 32'h0, dat_i = 32'h0;
  logic [31:0] wb_dat_o, ram_Di0;
  logic [31:0] ram_Do0 = 32'h0;
  logic wb_ack_o, wb_err_o, ram_EN0;
  logic [3:0] ram_WE0;
  logic [6:0] ram_A0;
  logic [31:0] ram [128] = '{default: 32'h0};
  logic [31:0] ref_mem [128] = '{default: 32'h0};
  logic [31:0] exp_dat = 32'h0;
  int checks = 0, errors = 0, cyc_cnt = 0;
  logic en_first, stray_en, got_ack, got_err, lingering;
  logic [3:0] we_first;
  logic [6:0] a_first;
  logic [31:0] rd;
  int lat, ack_cyc;

  dffram128x32_wb_ctrl dut (
    .CLK(clk), .RST(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we_i),
    .wb_sel_i(sel_i), .wb_adr_i(adr_i), .wb_dat_i(dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .ram_EN0(ram_EN0), .ram_WE0(ram_WE0),
    .ram_A0(ram_A0), .ram_Di0(ram_Di0), .ram_Do0(ram_Do0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Stand-in for the DFFRAM macro: byte-enabled write, read data one cycle after an enabled edge
  always @(posedge clk) begin
    if (ram_EN0) begin
      for (int b = 0; b < 4; b++)
        if (ram_WE0[b]) ram[ram_A0][8*b +: 8] <= ram_Di0[8*b +: 8];
      ram_Do0 <= ram[ram_A0];
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // One bus transaction held until ack/err (bounded); results left in globals for the caller to judge
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(negedge clk);
    lingering = wb_ack_o | wb_err_o;
    cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    #1;
    en_first = ram_EN0; we_first = ram_WE0; a_first = ram_A0;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; stray_en = 1'b0;
    while (!got_ack && !got_err && lat < 6) begin
      @(negedge clk);
      lat++;
      got_ack = wb_ack_o; got_err = wb_err_o;
      if (ram_EN0) stray_en = 1'b1;
    end
    rd = wb_dat_o; ack_cyc = cyc_cnt;
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = 32'h10; sel_i = 4'hF; dat_i = 32'h1234_5678;
    #1;
    checks++; if (ram_EN0 !== 1'b0 || ram_WE0 !== 4'h0) begin errors++; $display("FAIL reset_strobes en=%b we=%h want 0/0", ram_EN0, ram_WE0); end
    @(negedge clk);
    checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_outputs ack=%b err=%b dat=%h want 0/0/0", wb_ack_o, wb_err_o, wb_dat_o); end
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    ref_mem[4] = 32'hDEAD_BEEF;
    checks++; if ({en_first, we_first, a_first} !== {1'b1, 4'hF, 7'd4}) begin errors++; $display("FAIL wr_strobes en=%b we=%h a=%0d want 1/f/4", en_first, we_first, a_first); end
    checks++; if (!got_ack || got_err || lat != 1) begin errors++; $display("FAIL wr_ack ack=%b err=%b lat=%0d want 1/0/1", got_ack, got_err, lat); end
    xfer(1'b0, 32'h10, 32'h0, 4'hF);
    exp_dat = ref_mem[4];
    checks++; if ({en_first, we_first} !== {1'b1, 4'h0}) begin errors++; $display("FAIL rd_strobes en=%b we=%h want 1/0", en_first, we_first); end
    checks++; if (!got_ack || lat != 2 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data ack=%b lat=%0d dat=%h want 1/2/deadbeef", got_ack, lat, rd); end
  endtask

  task automatic test_byte_write;
    xfer(1'b1, 32'h10, 32'h0000_00AA, 4'b0001);
    ref_mem[4] = merge(ref_mem[4], 32'h0000_00AA, 4'b0001);
    checks++; if (!got_ack || we_first !== 4'b0001) begin errors++; $display("FAIL byte_wr ack=%b we=%h want 1/1", got_ack, we_first); end
    xfer(1'b1, 32'h10, 32'h5555_5555, 4'h0);
    checks++; if (!got_ack || lat != 1 || {en_first, we_first} !== {1'b1, 4'h0}) begin errors++; $display("FAIL sel0_wr ack=%b lat=%0d en=%b we=%h want 1/1/1/0", got_ack, lat, en_first, we_first); end
    xfer(1'b0, 32'h10, 32'h0, 4'hF);
    exp_dat = ref_mem[4];
    checks++; if (rd !== 32'hDEAD_BEAA || !got_ack) begin errors++; $display("FAIL byte_rd dat=%h ack=%b want deadbeaa/1", rd, got_ack); end
    checks++; if (lingering) begin errors++; $display("FAIL resp_single_cycle ack/err still high a cycle after RESP"); end
  endtask

  task automatic test_error;
    for (int w = 0; w < 2; w++) begin
      xfer(w[0], 32'h200, 32'hFFFF_FFFF, 4'hF);
      checks++; if (!got_err || got_ack || lat != 1) begin errors++; $display("FAIL miss_err we=%0d err=%b ack=%b lat=%0d want 1/0/1", w, got_err, got_ack, lat); end
      checks++; if (en_first || stray_en || rd !== exp_dat) begin errors++; $display("FAIL miss_side en=%b stray=%b dat=%h want 0/0/%h", en_first, stray_en, rd, exp_dat); end
    end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h20;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) seen = 1'b1;
    end
    checks++; if (seen || wb_dat_o !== exp_dat) begin errors++; $display("FAIL abort seen_resp=%b dat=%h want 0/%h", seen, wb_dat_o, exp_dat); end
    xfer(1'b1, 32'h24, 32'hCAFE_F00D, 4'hF);
    ref_mem[9] = 32'hCAFE_F00D;
    checks++; if (!got_ack || lat != 1) begin errors++; $display("FAIL abort_idle ack=%b lat=%0d want 1/1", got_ack, lat); end
  endtask

  task automatic test_reset_in_rd;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h24;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    exp_dat = 32'h0;
    checks++; if (wb_dat_o !== 32'h0 || wb_ack_o || wb_err_o) begin errors++; $display("FAIL rst_rd_outputs dat=%h ack=%b err=%b want 0/0/0", wb_dat_o, wb_ack_o, wb_err_o); end
    repeat (3) begin
      @(negedge clk);
      if (wb_ack_o || wb_err_o) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_rd_noack response after reset was %b want 0", seen); end
    xfer(1'b1, 32'h1FC, 32'h0BAD_CAFE, 4'hF);
    ref_mem[127] = 32'h0BAD_CAFE;
    checks++; if (!got_ack || a_first !== 7'd127 || !en_first) begin errors++; $display("FAIL word127_wr ack=%b a=%0d en=%b want 1/127/1", got_ack, a_first, en_first); end
  endtask

  task automatic test_back_to_back;
    int prev;
    logic [31:0] d;
    prev = 0;
    for (int i = 0; i < 128; i++) begin
      d = $urandom;
      xfer(1'b1, i * 4, d, 4'hF);
      ref_mem[i] = d;
      checks++; if (!got_ack || a_first !== i[6:0]) begin errors++; $display("FAIL b2b_wr word=%0d ack=%b a=%0d", i, got_ack, a_first); end
      if (i > 0) begin checks++; if (ack_cyc - prev != 2) begin errors++; $display("FAIL b2b_wr_gap word=%0d gap=%0d want 2", i, ack_cyc - prev); end end
      prev = ack_cyc;
    end
    for (int i = 0; i < 128; i++) begin
      xfer(1'b0, i * 4, 32'h0, 4'hF);
      exp_dat = ref_mem[i];
      checks++; if (!got_ack || rd !== ref_mem[i]) begin errors++; $display("FAIL b2b_rd word=%0d ack=%b dat=%h want %h", i, got_ack, rd, ref_mem[i]); end
      if (i > 0) begin checks++; if (ack_cyc - prev != 3) begin errors++; $display("FAIL b2b_rd_gap word=%0d gap=%0d want 3", i, ack_cyc - prev); end end
      prev = ack_cyc;
    end
  endtask

  task automatic test_random;
    logic we, miss;
    logic [31:0] adr, d;
    logic [3:0] s;
    int w;
    for (int n = 0; n < 200; n++) begin
      miss = ($urandom_range(0, 5) == 0);
      w = $urandom_range(0, 127);
      adr = miss ? {$urandom_range(1, 32'h7F_FFFF), 9'h0} | 32'($urandom_range(0, 511)) : 32'(w * 4 + $urandom_range(0, 3));
      we = $urandom_range(0, 1);
      d = $urandom;
      s = $urandom_range(0, 15);
      xfer(we, adr, d, s);
      if (miss) begin
        checks++; if (!got_err || got_ack || lat != 1 || en_first || rd !== exp_dat) begin errors++; $display("FAIL rnd_miss adr=%h err=%b ack=%b lat=%0d en=%b dat=%h want 1/0/1/0/%h", adr, got_err, got_ack, lat, en_first, rd, exp_dat); end
      end else if (we) begin
        ref_mem[w] = merge(ref_mem[w], d, s);
        checks++; if (!got_ack || got_err || lat != 1 || {en_first, we_first, a_first} !== {1'b1, s, w[6:0]} || rd !== exp_dat) begin errors++; $display("FAIL rnd_wr adr=%h ack=%b lat=%0d en=%b we=%h a=%0d dat=%h", adr, got_ack, lat, en_first, we_first, a_first, rd); end
      end else begin
        exp_dat = ref_mem[w];
        checks++; if (!got_ack || got_err || lat != 2 || rd !== exp_dat || a_first !== w[6:0]) begin errors++; $display("FAIL rnd_rd adr=%h ack=%b lat=%0d dat=%h want %h", adr, got_ack, lat, rd, exp_dat); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_write;
    test_error;
    test_abort;
    test_reset_in_rd;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dffram128x32_wb_ctrl.md
# dffram128x32_wb_ctrl

Wishbone classic slave controller placed directly upstream of the 128x32 DFFRAM macro. It turns CPU bus cycles into single-cycle RAM enable, write and address strobes, captures the RAM read data and returns acknowledge or error. A 512-byte window at `BASE_ADDR` maps onto the 128 RAM words; out-of-window accesses never touch the RAM.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: window base; bits [8:0] must be zero.
- `CLK` in 1: sole clock; RAM macro shares it.
- `RST` in 1: synchronous, active-high reset.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_sel_i` in 4: byte lane selects; bit n covers byte [8n+7:8n].
- `wb_adr_i` in 32: byte address.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, registered.
- `wb_ack_o` out 1: one-cycle acknowledge, registered.
- `wb_err_o` out 1: one-cycle error, registered.
- `ram_EN0` out 1: RAM enable.
- `ram_WE0` out 4: RAM byte write enables.
- `ram_A0` out 7: RAM word address, equal to `wb_adr_i[8:2]`.
- `ram_Di0` out 32: RAM write data, equal to `wb_dat_i`.
- `ram_Do0` in 32: RAM read data, valid in the cycle after an enabled read edge.

## Operation
- FSM states: IDLE, RD, RESP.
- Request = `wb_cyc_i & wb_stb_i` while in IDLE. Hit = `wb_adr_i[31:9] == BASE_ADDR[31:9]`.
- IDLE, request hit, write: `ram_EN0`=1 and `ram_WE0`=`wb_sel_i` combinationally in the same cycle. RAM writes at that edge. Set ack flag, go to RESP.
- IDLE, request hit, read: `ram_EN0`=1, `ram_WE0`=0. Go to RD.
- IDLE, request miss: RAM strobes stay 0. Set error flag, go to RESP.
- RD: if `wb_cyc_i`=1, register `ram_Do0` into `wb_dat_o`, set ack flag, go to RESP. If `wb_cyc_i`=0, abort to IDLE with no ack; `wb_dat_o` is unchanged.
- RESP: exactly one of `wb_ack_o` or `wb_err_o` is high for this single cycle. Next state is IDLE unconditionally. No new request is accepted in RESP.
- Write with `wb_sel_i`=0: still acked; `ram_EN0`=1, `ram_WE0`=0, no data change.
- `ram_EN0` and `ram_WE0` are 0 in every state other than IDLE-with-request, and 0 whenever `RST`=1.
- `ram_A0` and `ram_Di0` follow the bus inputs at all times; they are don't-care when `ram_EN0`=0.
- `wb_dat_o` holds its last read value across writes and errors.

## Timing
- Reset values: state IDLE, `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0; `ram_EN0`=0 and `ram_WE0`=0 while `RST` is high.
- Write: request in cycle N, `wb_ack_o` high in cycle N+1.
- Read: request in cycle N, `ram_Do0` valid in N+1, `wb_ack_o` and `wb_dat_o` valid in N+2.
- Error: request in cycle N, `wb_err_o` high in N+1.
- Back-to-back: the earliest next request is accepted in the cycle after RESP. Throughput is 1 write per 2 cycles and 1 read per 3 cycles.
- `RST` asserted in any state returns the FSM to IDLE at the next edge. Any pending ack or error is dropped, and no RAM strobe is issued in the reset cycle.
- A request held through RESP is not double-accepted: RESP exits to IDLE, and the master must have dropped `wb_stb_i` after the ack.

## Test plan
- Write 0xDEADBEEF to 0x0000_0010 with sel=4'hF -> `ram_EN0`=1, `ram_WE0`=F, `ram_A0`=4 in cycle N; ack in N+1. Read back the same address -> ack in N+2 with `wb_dat_o`=0xDEADBEEF.
- Byte write 0x000000AA with sel=4'b0001 to word 4, then read -> 0xDEADBEAA.
- Access to 0x0000_0200 with `BASE_ADDR`=0 -> `wb_err_o` one cycle, no ack, `ram_EN0` never high.
- Read issued, then `wb_cyc_i` dropped in RD -> no ack, `wb_dat_o` keeps its previous value, FSM back in IDLE.
- `RST` pulsed during RD -> no ack in any following cycle. Outputs are 0 after reset, and a subsequent write to word 127 (addr 0x1FC) succeeds with `ram_A0`=127.
- Back-to-back writes to words 0..127, then reads of all 128 words -> all data match, with ack spacing of exactly 2 cycles for writes and 3 cycles for reads.
